// File: rtl/onchip_mem_dp_if.sv
// Avalon-MM slave port bundle for onchip_mem_dp.
// Ports (master view):
//   address, byteenable, read, write, writedata : driven by the bus master
//   readdata, readdatavalid, waitrequest        : driven by the memory
interface onchip_mem_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_mem_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slave ports (s1 CPU data,
// s2 Ethernet DMA), pipelined reads with readdatavalid, and a post-reset
// clear sequencer.
// Ports:
//   clk, reset (sync, active high), clken (0 freezes all state)
//   s1, s2     : onchip_mem_dp_if.slave bus ports
//   busy       : clear sequence in progress
//   parity_err : sticky byte-parity error, bit0 = s1, bit1 = s2
// Optional: define ONCHIP_MEM_PARITY_EN to store one even-parity bit per
// byte and flag mismatches on returned reads; otherwise parity_err = 0.
//
// state    | meaning
// ST_CLEAR | writing INIT_WORD to every address, ports stalled
// ST_READY | normal operation
module onchip_mem_dp #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 12,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_WORD      = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  onchip_mem_dp_if.slave        s1,
  onchip_mem_dp_if.slave        s2,
  output logic                  busy,
  output logic [1:0]            parity_err
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef ONCHIP_MEM_PARITY_EN
  localparam int MW    = DATA_WIDTH + NB;  // {parity[NB-1:0], data}
`else
  localparam int MW    = DATA_WIDTH;
`endif
  localparam logic CLR_EN = (CLEAR_ON_RESET != 0);

  function automatic logic [MW-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [MW-1:0] w;
    w = '0;
    w[DATA_WIDTH-1:0] = d;
`ifdef ONCHIP_MEM_PARITY_EN
    for (int b = 0; b < NB; b++) w[DATA_WIDTH+b] = ^d[8*b +: 8];
`endif
    return w;
  endfunction

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_we;
  logic                  busy_w, wait_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLR_EN ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else if (clken) begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = clken & ~reset;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);  // wraps to 0 after the last address
        if (&clr_cnt_q) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  // While reset is held the registered state is not yet meaningful, so the
  // stall/busy level reflects where reset will put the sequencer.
  always_comb begin
    if (reset) begin
      busy_w = CLR_EN;
      wait_w = CLR_EN;
    end else begin
      busy_w = (state_q == ST_CLEAR);
      wait_w = busy_w | ~clken;
    end
  end

  assign busy           = busy_w;
  assign s1.waitrequest = wait_w;
  assign s2.waitrequest = wait_w;

  logic [1:0] acc_w, we_w, re_w;
  assign acc_w[0] = (s1.read | s1.write) & ~wait_w & clken & ~reset;
  assign acc_w[1] = (s2.read | s2.write) & ~wait_w & clken & ~reset;
  // A simultaneous read+write on one port executes only the write.
  assign we_w = acc_w &  {s2.write, s1.write};
  assign re_w = acc_w & ~{s2.write, s1.write};

  logic [MW-1:0] mem_q [DEPTH];

  // s1 lanes are written after s2 lanes so s1 wins on overlapping bytes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= encode(INIT_WORD);
    end else begin
      if (we_w[1]) begin
        for (int b = 0; b < NB; b++) begin
          if (s2.byteenable[b]) begin
            mem_q[s2.address][8*b +: 8] <= s2.writedata[8*b +: 8];
`ifdef ONCHIP_MEM_PARITY_EN
            mem_q[s2.address][DATA_WIDTH+b] <= ^s2.writedata[8*b +: 8];
`endif
          end
        end
      end
      if (we_w[0]) begin
        for (int b = 0; b < NB; b++) begin
          if (s1.byteenable[b]) begin
            mem_q[s1.address][8*b +: 8] <= s1.writedata[8*b +: 8];
`ifdef ONCHIP_MEM_PARITY_EN
            mem_q[s1.address][DATA_WIDTH+b] <= ^s1.writedata[8*b +: 8];
`endif
          end
        end
      end
    end
  end

  logic [MW-1:0] rd_w [2];
  assign rd_w[0] = mem_q[s1.address];
  assign rd_w[1] = mem_q[s2.address];

  logic [1:0]    src_v;
  logic [MW-1:0] src_d [2];

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [1:0]    v1_q;
      logic [MW-1:0] d1_q [2];
      always_ff @(posedge clk) begin
        if (reset) begin
          v1_q    <= '0;
          d1_q[0] <= '0;
          d1_q[1] <= '0;
        end else if (clken) begin
          v1_q <= re_w;
          for (int p = 0; p < 2; p++) if (re_w[p]) d1_q[p] <= rd_w[p];
        end
      end
      assign src_v    = v1_q;
      assign src_d[0] = d1_q[0];
      assign src_d[1] = d1_q[1];
    end else begin : g_lat1
      assign src_v    = re_w;
      assign src_d[0] = rd_w[0];
      assign src_d[1] = rd_w[1];
    end
  endgenerate

  logic [1:0]    vo_q;
  logic [MW-1:0] do_q [2];

  // Output data only moves with a valid result, so readdata holds between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      vo_q    <= '0;
      do_q[0] <= '0;
      do_q[1] <= '0;
    end else if (clken) begin
      vo_q <= src_v;
      for (int p = 0; p < 2; p++) if (src_v[p]) do_q[p] <= src_d[p];
    end
  end

  assign s1.readdata      = do_q[0][DATA_WIDTH-1:0];
  assign s2.readdata      = do_q[1][DATA_WIDTH-1:0];
  // A result pending across a freeze is shown only once clken returns.
  assign s1.readdatavalid = vo_q[0] & clken & ~reset;
  assign s2.readdatavalid = vo_q[1] & clken & ~reset;

`ifdef ONCHIP_MEM_PARITY_EN
  logic [1:0] perr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= '0;
    end else if (clken) begin
      for (int p = 0; p < 2; p++)
        if (vo_q[p] && (encode(do_q[p][DATA_WIDTH-1:0]) != do_q[p])) perr_q[p] <= 1'b1;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 2'b00;
`endif
endmodule

// File: tb/tb_onchip_mem_dp.sv
module tb_onchip_mem_dp;
  localparam int          DW    = 32;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] INIT  = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clken = 1'b1;
  logic [1:0] busy_w;
  logic [1:0] perr_a, perr_b;

  onchip_mem_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1a ();
  onchip_mem_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s2a ();
  onchip_mem_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1b ();
  onchip_mem_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s2b ();

  always #5 clk = ~clk;

  onchip_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1),
                  .CLEAR_ON_RESET(1), .INIT_WORD(INIT)) u_dut_l1 (
    .clk(clk), .reset(reset), .clken(clken), .s1(s1a), .s2(s2a),
    .busy(busy_w[0]), .parity_err(perr_a));

  onchip_mem_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2),
                  .CLEAR_ON_RESET(1), .INIT_WORD(INIT)) u_dut_l2 (
    .clk(clk), .reset(reset), .clken(clken), .s1(s1b), .s2(s2b),
    .busy(busy_w[1]), .parity_err(perr_b));

  // The latency-2 instance sees exactly the same requests.
  assign s1b.address = s1a.address;  assign s1b.byteenable = s1a.byteenable;
  assign s1b.read    = s1a.read;     assign s1b.write      = s1a.write;
  assign s1b.writedata = s1a.writedata;
  assign s2b.address = s2a.address;  assign s2b.byteenable = s2a.byteenable;
  assign s2b.read    = s2a.read;     assign s2b.write      = s2a.write;
  assign s2b.writedata = s2a.writedata;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        expq [4][$];   // 0: l1.s1, 1: l1.s2, 2: l2.s1, 3: l2.s2
  logic [31:0] model [DEPTH];
  int unsigned ecnt = 0;      // enabled clock edges seen so far
  int          tests = 0;
  int          fails = 0;

  logic [3:0]  rdv_w;
  logic [31:0] rdd_w [4];
  assign rdv_w    = {s2b.readdatavalid, s1b.readdatavalid, s2a.readdatavalid, s1a.readdatavalid};
  assign rdd_w[0] = s1a.readdata;
  assign rdd_w[1] = s2a.readdata;
  assign rdd_w[2] = s1b.readdata;
  assign rdd_w[3] = s2b.readdata;

  always @(posedge clk) if (clken) ecnt <= ecnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expected read
  // of that port, both in data and in the enabled cycle it appears on.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (rdv_w[k] === 1'b1) begin
        if (expq[k].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rdv[%0d]: got valid with data %0h expected no valid", k, rdd_w[k]);
        end else begin
          e = expq[k].pop_front();
          check($sformatf("rdata[%0d]", k), 64'(rdd_w[k]), 64'(e.data));
          check($sformatf("rdv_cycle[%0d]", k), 64'(ecnt), 64'(e.due));
        end
      end
    end
  end

  task automatic model_write(input logic [3:0] a, input logic [3:0] be, input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (be[b]) model[a][8*b +: 8] = wd[8*b +: 8];
  endtask

  // op: bit0 = read, bit1 = write. Called #1 after a rising edge; returns #1
  // after the edge at which the request is sampled.
  task automatic drive(input logic [1:0] op1, input logic [3:0] a1, input logic [3:0] be1,
                       input logic [31:0] wd1, input logic [1:0] op2, input logic [3:0] a2,
                       input logic [3:0] be2, input logic [31:0] wd2, input logic ce);
    s1a.read = op1[0]; s1a.write = op1[1]; s1a.address = a1;
    s1a.byteenable = be1; s1a.writedata = wd1;
    s2a.read = op2[0]; s2a.write = op2[1]; s2a.address = a2;
    s2a.byteenable = be2; s2a.writedata = wd2;
    clken = ce;
    if (ce) begin
      // reads see the memory as it was before this cycle's writes
      if (op1 == 2'b01) begin
        expq[0].push_back('{model[a1], ecnt + 1});
        expq[2].push_back('{model[a1], ecnt + 2});
      end
      if (op2 == 2'b01) begin
        expq[1].push_back('{model[a2], ecnt + 1});
        expq[3].push_back('{model[a2], ecnt + 2});
      end
      if (op2[1]) model_write(a2, be2, wd2);
      if (op1[1]) model_write(a1, be1, wd1);   // s1 applied last: wins overlaps
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ce);
    drive(2'b00, 4'd0, 4'h0, 32'h0, 2'b00, 4'd0, 4'h0, 32'h0, ce);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    s1a.read = 0; s1a.write = 0; s1a.address = '0; s1a.byteenable = '0; s1a.writedata = '0;
    s2a.read = 0; s2a.write = 0; s2a.address = '0; s2a.byteenable = '0; s2a.writedata = '0;
    reset = 1'b1;
    clken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy_w), 64'h3);
    check("rst_wait", 64'({s1a.waitrequest, s2a.waitrequest, s1b.waitrequest, s2b.waitrequest}), 64'hF);
    check("rst_rdv", 64'(rdv_w), 64'h0);
    check("rst_rdata", 64'({s1a.readdata, s2b.readdata}), 64'h0);
    check("rst_perr", 64'({perr_a, perr_b}), 64'h0);
    reset = 1'b0;

    // restart the clear part way through
    repeat (6) @(posedge clk);
    #1;
    check("mid_clear_busy", 64'(busy_w), 64'h3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rerst_busy", 64'(busy_w), 64'h3);
    reset = 1'b0;
    n = 0;
    while (busy_w[0] === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("clear_cycles", 64'(n), 64'd16);
    check("busy_done", 64'(busy_w), 64'h0);
    check("wait_done", 64'({s1a.waitrequest, s2a.waitrequest, s1b.waitrequest, s2b.waitrequest}), 64'h0);
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;

    // every location cleared; s2 walks downwards at the same time
    for (int i = 0; i < DEPTH; i++)
      drive(2'b01, 4'(i), 4'hF, 32'h0, 2'b01, 4'(15 - i), 4'hF, 32'h0, 1'b1);

    // write then read next cycle, plus four back-to-back reads
    drive(2'b10, 4'd5, 4'hF, 32'h11223344, 2'b00, 4'd0, 4'h0, 32'h0, 1'b1);
    drive(2'b01, 4'd5, 4'hF, 32'h0, 2'b00, 4'd0, 4'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++)
      drive(2'b01, 4'(4 + i), 4'hF, 32'h0, 2'b00, 4'd0, 4'h0, 32'h0, 1'b1);

    // byte enables
    drive(2'b10, 4'd3, 4'hF, 32'hFFFFFFFF, 2'b00, 4'd0, 4'h0, 32'h0, 1'b1);
    drive(2'b10, 4'd3, 4'h1, 32'h000000AA, 2'b00, 4'd0, 4'h0, 32'h0, 1'b1);
    drive(2'b01, 4'd3, 4'hF, 32'h0, 2'b00, 4'd0, 4'h0, 32'h0, 1'b1);

    // write/write collision on one address
    drive(2'b10, 4'd7, 4'hC, 32'hAAAA0000, 2'b10, 4'd7, 4'hF, 32'h5555BBBB, 1'b1);
    drive(2'b01, 4'd7, 4'hF, 32'h0, 2'b01, 4'd7, 4'hF, 32'h0, 1'b1);

    // read/write collision returns old data
    drive(2'b10, 4'd9, 4'hF, 32'h0, 2'b00, 4'd0, 4'h0, 32'h0, 1'b1);
    drive(2'b10, 4'd9, 4'hF, 32'h1, 2'b01, 4'd9, 4'hF, 32'h0, 1'b1);
    drive(2'b01, 4'd9, 4'hF, 32'h0, 2'b01, 4'd9, 4'hF, 32'h0, 1'b1);

    // illegal read+write on one port: only the write happens
    drive(2'b11, 4'd2, 4'hF, 32'hCAFEF00D, 2'b00, 4'd0, 4'h0, 32'h0, 1'b1);
    drive(2'b00, 4'd0, 4'h0, 32'h0, 2'b01, 4'd2, 4'hF, 32'h0, 1'b1);

    // freeze right after an accepted read
    drive(2'b01, 4'd5, 4'hF, 32'h0, 2'b00, 4'd0, 4'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      clken = 1'b0;
      s1a.read = 0; s1a.write = 0; s2a.read = 0; s2a.write = 0;
      #2;
      check($sformatf("freeze_rdv%0d", i), 64'(rdv_w), 64'h0);
      @(posedge clk);
      #1;
    end
    repeat (3) idle(1'b1);

    // random traffic with occasional freezes
    for (int i = 0; i < 400; i++)
      drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 7) != 0));

    repeat (6) idle(1'b1);
    for (int k = 0; k < 4; k++)
      check($sformatf("pending[%0d]", k), 64'(expq[k].size()), 64'd0);
    check("parity_err", 64'({perr_a, perr_b}), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/onchip_mem_dp.md
Name: onchip_mem_dp

Overview:
- Parametrised successor to the single-port NIOS data RAM.
- True dual-port on-chip memory with two Avalon-MM slave ports (s1 for the CPU data master, s2 for the Ethernet DMA/packet buffer).
- Adds configurable width and depth, pipelined read latency with readdatavalid, waitrequest, a post-reset clear sequencer, and defined cross-port collision rules.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 12, word address bits; depth = 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from an accepted read to readdatavalid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = write INIT_WORD to every location after reset; 0 = memory ready immediately.
- INIT_WORD, 0, clear value, DATA_WIDTH bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  global clock enable; 0 freezes all state.
- s1_address  in  ADDR_WIDTH  port 1 word address.
- s1_byteenable  in  DATA_WIDTH/8  port 1 byte lanes.
- s1_read  in  1  port 1 read request.
- s1_write  in  1  port 1 write request.
- s1_writedata  in  DATA_WIDTH  port 1 write data.
- s1_readdata  out  DATA_WIDTH  port 1 read data.
- s1_readdatavalid  out  1  port 1 read data strobe.
- s1_waitrequest  out  1  port 1 stall.
- s2_*  same set as s1_*, for port 2.
- busy  out  1  clear sequence in progress.
- parity_err  out  2  sticky parity error, bit0 = s1, bit1 = s2.

Behaviour:
- Reset values: readdata = 0, readdatavalid = 0, parity_err = 0.
  - With CLEAR_ON_RESET = 1: busy = 1 and waitrequest = 1 on both ports during reset.
  - With CLEAR_ON_RESET = 0: busy = 0 and waitrequest = 0 on both ports.
  - Memory contents are not affected by reset except through the clear sequence.
- FSM states: CLEAR, READY.
  - Reset enters CLEAR if CLEAR_ON_RESET = 1, otherwise READY.
  - CLEAR: a counter starts at 0 and writes INIT_WORD with all bytes enabled, one address per enabled cycle. After writing address 2**ADDR_WIDTH-1 the counter wraps to 0 and the FSM moves to READY on the same edge.
  - CLEAR takes exactly 2**ADDR_WIDTH enabled cycles. busy and both waitrequests fall the following cycle.
  - Reset asserted mid-CLEAR restarts the counter at 0.
- Transfer acceptance: a request is accepted when (read | write) & ~waitrequest & clken.
  - In READY, waitrequest = ~clken.
  - read and write asserted together on one port is illegal: the write executes and the read is ignored.
- Writes: only lanes with byteenable = 1 are updated. The data is visible to a read accepted on the next cycle.
- Reads:
  - readdatavalid pulses exactly READ_LATENCY enabled cycles after acceptance, one pulse per accepted read, in order.
  - Back-to-back reads sustain one result per cycle.
  - readdata holds its last value while readdatavalid = 0.
- clken = 0 freezes the FSM, the clear counter, the read pipeline and the output registers. readdatavalid is held at 0 while frozen and the pending result is emitted after clken returns.
- Collisions:
  - Both ports write the same address in the same cycle: s1 bytes win on overlapping lanes, s2 bytes land on non-overlapping lanes.
  - One port reads an address the other port writes in the same cycle: the read returns the old data.
  - A port reading the address it is writing cannot occur (see illegal case above).
- Address arithmetic: word-addressed, no wrap beyond the depth. All ADDR_WIDTH bits are used.

Optional Feature:
- ONCHIP_MEM_PARITY_EN defined:
  - One even-parity bit is stored per byte, computed on write. The clear sequence writes the parity of INIT_WORD.
  - On each readdatavalid, any byte parity mismatch sets parity_err[port]. The bit is sticky until reset.
  - Read data is returned unmodified.
- Undefined: no parity storage, and parity_err is tied to 0.

Test Plan:
- CLEAR_ON_RESET = 1, ADDR_WIDTH = 4, INIT_WORD = 32'hDEADBEEF, reset for 1 cycle -> busy high for exactly 16 cycles; then s1 reads of addresses 0..15 all return 32'hDEADBEEF with readdatavalid 1 cycle after each read.
- READ_LATENCY = 2: s1 writes 32'h11223344 to address 5, then s1 reads address 5 on the next cycle -> readdatavalid 2 cycles later with 32'h11223344. Four back-to-back reads produce four consecutive valid pulses.
- Byte enables: write 32'hFFFFFFFF to address 3, then write 32'h000000AA with byteenable 4'b0001 -> address 3 reads 32'hFFFFFFAA.
- Collision:
  - Same cycle, s1 writes 32'hAAAA0000 with byteenable 4'b1100 and s2 writes 32'h5555BBBB with byteenable 4'b1111, both to address 7 -> address 7 reads 32'hAAAABBBB.
  - Same cycle, s2 reads address 9 while s1 writes 32'h1 to it (old value 32'h0) -> s2 gets 32'h0.
- clken deasserted for 3 cycles right after a read is accepted (READ_LATENCY = 1) -> no readdatavalid during the freeze; the pulse appears on the first cycle after clken returns, with the correct data.
- Reset asserted at clear count 6 -> busy stays high; the clear restarts from 0 and takes the full 2**ADDR_WIDTH cycles. With ONCHIP_MEM_PARITY_EN defined, corrupting a stored parity bit via force and then reading on s2 -> parity_err = 2'b10, held until reset.
